// File: rtl/vend_credit_ctrl_if.sv
// Front-panel / display bundle for the vending credit controller.
//
// Handshake: there is no valid/ready pair. Inputs are synchronous levels that
// the controller edge-detects itself; every output is a registered level or a
// one-cycle pulse, valid on every cycle after reset is released.
//
// fsm_state is a debug view of the controller state:
// 0 = IDLE, 1 = ACCUM, 2 = VEND, 3 = CHANGE.
interface vend_credit_ctrl_if;
  logic       coin_a;
  logic       coin_b;
  logic       sel;
  logic       cancel;
  logic [3:0] digit;
  logic       dispense;
  logic       change_pulse;
  logic       coin_reject;
  logic       busy;
  logic       credit_full;
  logic [1:0] fsm_state;

  modport master (
    output coin_a, coin_b, sel, cancel,
    input  digit, dispense, change_pulse, coin_reject, busy, credit_full, fsm_state
  );

  modport slave (
    input  coin_a, coin_b, sel, cancel,
    output digit, dispense, change_pulse, coin_reject, busy, credit_full, fsm_state
  );
endinterface

// File: rtl/vend_credit_ctrl.sv
// Vending credit sequencer: accumulates coin credit, grants a purchase,
// holds dispense for DISP_CYCLES cycles, then returns change one unit per
// cycle. The stored credit never exceeds MAX_CREDIT (<= 8) so the digit
// output always stays inside the seven-segment decoder range.
module vend_credit_ctrl #(
  parameter int unsigned PRICE       = 3,
  parameter int unsigned MAX_CREDIT  = 8,
  parameter int unsigned DISP_CYCLES = 4
) (
  input  logic              clk,
  input  logic              reset,
  vend_credit_ctrl_if.slave bus
);

  localparam int CW = (DISP_CYCLES > 1) ? $clog2(DISP_CYCLES) : 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCUM  = 2'd1,
    ST_VEND   = 2'd2,
    ST_CHANGE = 2'd3
  } state_t;

  state_t        state, state_n;
  logic [3:0]    credit, credit_n;
  logic [CW-1:0] cnt, cnt_n;

  // Input bit order: {cancel, sel, coin_b, coin_a}
  logic [3:0] in_q, prev_q, ev;

  logic dispense_q, dispense_n;
  logic change_q, change_n;
  logic reject_q, reject_n;
  logic busy_q, full_q;

  logic       coin_ev;
  logic [4:0] add, sum;

  // Two-stage sampling: in_q is the current sample, prev_q the one before.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_q   <= '0;
      prev_q <= '0;
    end else begin
      in_q   <= {bus.cancel, bus.sel, bus.coin_b, bus.coin_a};
      prev_q <= in_q;
    end
  end

  assign ev      = in_q & ~prev_q;
  assign coin_ev = ev[0] | ev[1];
  assign add     = {3'b000, ev[1], ev[0]};
  // 5-bit sum so credit + 3 cannot wrap before the ceiling test.
  assign sum     = {1'b0, credit} + add;

  // State, credit and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      credit     <= '0;
      cnt        <= '0;
      dispense_q <= 1'b0;
      change_q   <= 1'b0;
      reject_q   <= 1'b0;
      busy_q     <= 1'b0;
      full_q     <= 1'b0;
    end else begin
      state      <= state_n;
      credit     <= credit_n;
      cnt        <= cnt_n;
      dispense_q <= dispense_n;
      change_q   <= change_n;
      reject_q   <= reject_n;
      busy_q     <= (state_n == ST_VEND) || (state_n == ST_CHANGE);
      full_q     <= (credit_n == 4'(MAX_CREDIT));
    end
  end

  // Next-state logic; priority cancel > sel > coins, and only an action that
  // takes effect pre-empts a coin (an ignored sel/cancel lets coins through).
  always_comb begin
    state_n    = state;
    credit_n   = credit;
    cnt_n      = cnt;
    dispense_n = 1'b0;
    change_n   = 1'b0;
    reject_n   = 1'b0;
    case (state)
      ST_IDLE, ST_ACCUM: begin
        if (ev[3] && (state == ST_ACCUM)) begin
          state_n  = ST_CHANGE;
          reject_n = coin_ev;
        end else if (ev[2] && (state == ST_ACCUM) &&
                     ({1'b0, credit} >= 5'(PRICE))) begin
          state_n    = ST_VEND;
          credit_n   = credit - 4'(PRICE);
          cnt_n      = CW'(DISP_CYCLES - 1);
          dispense_n = 1'b1;
          reject_n   = coin_ev;
        end else if (coin_ev) begin
          if (sum > 5'(MAX_CREDIT)) begin
            reject_n = 1'b1;
          end else begin
            credit_n = sum[3:0];
            state_n  = ST_ACCUM;
          end
        end
      end
      ST_VEND: begin
        reject_n = coin_ev;
        if (cnt != '0) begin
          cnt_n      = cnt - CW'(1);
          dispense_n = 1'b1;
        end else begin
          state_n = (credit != 4'd0) ? ST_CHANGE : ST_IDLE;
        end
      end
      ST_CHANGE: begin
        reject_n = coin_ev;
        if (credit != 4'd0) begin
          credit_n = credit - 4'd1;
          change_n = 1'b1;
        end
        if (credit <= 4'd1) begin
          state_n = ST_IDLE;
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  assign bus.digit        = credit;
  assign bus.dispense     = dispense_q;
  assign bus.change_pulse = change_q;
  assign bus.coin_reject  = reject_q;
  assign bus.busy         = busy_q;
  assign bus.credit_full  = full_q;
  assign bus.fsm_state    = state;

endmodule

// File: tb/tb_vend_credit_ctrl.sv
// Bench for vend_credit_ctrl: directed walk through the purchase, refund and
// overflow cases followed by randomized front-panel activity, all checked
// against a transaction-level credit model.
module tb_vend_credit_ctrl;

  localparam int PRICE       = 3;
  localparam int MAX_CREDIT  = 8;
  localparam int DISP_CYCLES = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  vend_credit_ctrl_if bus();

  vend_credit_ctrl #(
    .PRICE(PRICE), .MAX_CREDIT(MAX_CREDIT), .DISP_CYCLES(DISP_CYCLES)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // Expected vector: [10:7] digit, [6] dispense, [5] change, [4] reject,
  // [3] busy, [2] full, [1:0] state
  logic [10:0] exp_q[$];

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int         m_credit;
  int         m_disp_left;   // dispense cycles still owed, current one included
  bit         m_refund;      // returning change
  bit         m_pulse;
  bit         m_reject;
  logic [3:0] h1, h2;        // panel samples at the last two edges

  function automatic void model_reset();
    m_credit = 0; m_disp_left = 0; m_refund = 0;
    m_pulse = 0; m_reject = 0; h1 = '0; h2 = '0;
  endfunction

  task automatic model_step(input logic [3:0] cur);
    logic [3:0]  ev;
    bit          coin;
    int          add;
    int          st;
    logic [10:0] e;
    ev   = h1 & ~h2;
    h2   = h1;
    h1   = cur;
    coin = ev[0] | ev[1];
    add  = int'(ev[0]) + 2 * int'(ev[1]);
    m_pulse  = 0;
    m_reject = 0;
    if (m_disp_left > 0) begin
      m_reject = coin;
      m_disp_left--;
      if (m_disp_left == 0 && m_credit > 0) m_refund = 1;
    end else if (m_refund) begin
      m_reject = coin;
      m_credit--;
      m_pulse = 1;
      if (m_credit == 0) m_refund = 0;
    end else if (ev[3] && m_credit > 0) begin
      m_refund = 1;
      m_reject = coin;
    end else if (ev[2] && m_credit >= PRICE) begin
      m_credit   -= PRICE;
      m_disp_left = DISP_CYCLES;
      m_reject    = coin;
    end else if (coin) begin
      if (m_credit + add > MAX_CREDIT) m_reject = 1;
      else m_credit += add;
    end
    st = (m_disp_left > 0) ? 2 : m_refund ? 3 : (m_credit > 0) ? 1 : 0;
    e[10:7] = 4'(m_credit);
    e[6]    = (m_disp_left > 0);
    e[5]    = m_pulse;
    e[4]    = m_reject;
    e[3]    = (m_disp_left > 0) || m_refund;
    e[2]    = (m_credit == MAX_CREDIT);
    e[1:0]  = 2'(st);
    exp_q.push_back(e);
  endtask

  // ---------------- scoreboard ----------------
  task automatic check_outputs();
    logic [10:0] e;
    if (exp_q.size() == 0) begin
      check_val("exp_q_empty", 1, 0);
      return;
    end
    e = exp_q.pop_front();
    check_val("digit",        bus.digit,        e[10:7]);
    check_val("dispense",     bus.dispense,     e[6]);
    check_val("change_pulse", bus.change_pulse, e[5]);
    check_val("coin_reject",  bus.coin_reject,  e[4]);
    check_val("busy",         bus.busy,         e[3]);
    check_val("credit_full",  bus.credit_full,  e[2]);
    check_val("fsm_state",    bus.fsm_state,    e[1:0]);
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle(input logic a, input logic b, input logic s, input logic c);
    bus.coin_a = a; bus.coin_b = b; bus.sel = s; bus.cancel = c;
    @(posedge clk);
    model_step({c, s, b, a});
    @(negedge clk);
    check_outputs();
  endtask

  // Press and release: the event is visible at outputs when this returns.
  task automatic pulse(input logic a, input logic b, input logic s, input logic c);
    cycle(a, b, s, c);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Asserted away from the clock edge; outputs must clear without a clock.
  task automatic apply_reset();
    reset = 1'b1;
    #1;
    check_val("rst_digit",    bus.digit,        0);
    check_val("rst_dispense", bus.dispense,     0);
    check_val("rst_change",   bus.change_pulse, 0);
    check_val("rst_reject",   bus.coin_reject,  0);
    check_val("rst_busy",     bus.busy,         0);
    check_val("rst_full",     bus.credit_full,  0);
    check_val("rst_state",    bus.fsm_state,    0);
    model_reset();
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.coin_a = 1'b0; bus.coin_b = 1'b0; bus.sel = 1'b0; bus.cancel = 1'b0;
    apply_reset();

    // coin_a then coin_b
    pulse(1, 0, 0, 0);
    check_val("digit_1", bus.digit, 1);
    pulse(0, 1, 0, 0);
    check_val("digit_3", bus.digit, 3);
    check_val("accum_state", bus.fsm_state, 1);
    check_val("no_reject", bus.coin_reject, 0);

    // exact-price purchase, no change
    pulse(0, 0, 1, 0);
    check_val("vend_digit0", bus.digit, 0);
    check_val("vend_disp", bus.dispense, 1);
    check_val("vend_busy", bus.busy, 1);
    idle(3);
    check_val("vend_disp_last", bus.dispense, 1);
    idle(1);
    check_val("vend_disp_off", bus.dispense, 0);
    check_val("vend_to_idle", bus.fsm_state, 0);

    // overflow refusal then fill to the ceiling
    pulse(0, 1, 0, 0); pulse(0, 1, 0, 0); pulse(0, 1, 0, 0); pulse(1, 0, 0, 0);
    check_val("digit_7", bus.digit, 7);
    pulse(0, 1, 0, 0);
    check_val("ovf_reject", bus.coin_reject, 1);
    check_val("ovf_digit7", bus.digit, 7);
    pulse(1, 0, 0, 0);
    check_val("digit_8", bus.digit, 8);
    check_val("full_8", bus.credit_full, 1);
    pulse(0, 0, 1, 0);
    idle(DISP_CYCLES + 6);
    check_val("after_8_idle", bus.digit, 0);

    // credit 5, purchase, two units of change
    pulse(0, 1, 0, 0); pulse(0, 1, 0, 0); pulse(1, 0, 0, 0);
    pulse(0, 0, 1, 0);
    idle(4);
    check_val("chg_entry_digit", bus.digit, 2);
    check_val("chg_entry_state", bus.fsm_state, 3);
    idle(1);
    check_val("chg_pulse1", bus.change_pulse, 1);
    check_val("chg_digit1", bus.digit, 1);
    idle(1);
    check_val("chg_digit0", bus.digit, 0);
    check_val("chg_done_state", bus.fsm_state, 0);
    idle(1);

    // sel below price ignored, cancel refunds, coin during refund refused
    pulse(0, 1, 0, 0);
    pulse(0, 0, 1, 0);
    check_val("sel_low_digit", bus.digit, 2);
    check_val("sel_low_nodisp", bus.dispense, 0);
    pulse(0, 0, 0, 1);
    check_val("cancel_state", bus.fsm_state, 3);
    pulse(1, 0, 0, 0);
    check_val("chg_coin_reject", bus.coin_reject, 1);
    check_val("chg_coin_digit", bus.digit, 0);
    idle(2);

    // cancel + sel + coin together at credit 4
    pulse(0, 1, 0, 0); pulse(0, 1, 0, 0);
    pulse(1, 0, 1, 1);
    check_val("multi_state", bus.fsm_state, 3);
    check_val("multi_reject", bus.coin_reject, 1);
    check_val("multi_digit", bus.digit, 4);
    idle(6);

    // both coins at credit 0, purchase, reset in 2nd dispense cycle
    pulse(1, 1, 0, 0);
    check_val("ab_digit3", bus.digit, 3);
    pulse(0, 0, 1, 0);
    idle(1);
    check_val("disp_cycle2", bus.dispense, 1);
    apply_reset();

    // randomized panel activity with occasional resets
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        apply_reset();
      end else begin
        cycle(1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 3) == 0),
              1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 11) == 0));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/vend_credit_ctrl.md
Name: vend_credit_ctrl

Overview:
Vending-machine sequencing FSM that accumulates coin credit, grants a purchase, and returns change one unit per cycle. It owns the 4-bit credit value that feeds the seven-segment decoder (valid range 0-8) and guarantees that value never leaves that range. It sits between the debounced front-panel inputs and the display/dispense hardware.

Parameters:
PRICE, 3, item cost in credit units; legal range 1..MAX_CREDIT
MAX_CREDIT, 8, credit ceiling; must be <= 8 so the decoder range is never exceeded
DISP_CYCLES, 4, number of cycles the dispense output is held high; legal range >= 1

Ports:
clk  in  1  system clock, rising-edge active
reset  in  1  asynchronous, active-high reset
coin_a  in  1  coin worth 1 unit, synchronous level, edge-detected internally
coin_b  in  1  coin worth 2 units, synchronous level, edge-detected internally
sel  in  1  purchase button, edge-detected internally
cancel  in  1  refund button, edge-detected internally
digit  out  4  current credit, 0..MAX_CREDIT, to the seven-segment decoder
dispense  out  1  high for DISP_CYCLES cycles per granted purchase
change_pulse  out  1  one cycle high per unit of change returned
coin_reject  out  1  one cycle high when a coin event is refused
busy  out  1  high in VEND and CHANGE
credit_full  out  1  high when credit == MAX_CREDIT

Behaviour:
- Reset (async assert, sync-safe deassert): state IDLE, credit 0, edge-detect registers 0, dispense/change_pulse/coin_reject 0, digit 0, busy 0, credit_full 0.
- Edge detect: an input event is a 0->1 transition between consecutive clk samples; a held-high input counts once. Registers for prior samples reset to 0, so an input already high when reset is released counts as an event on the first clock.
- All outputs are registered; an event sampled at edge N is reflected at outputs after edge N+1 (one-cycle latency).
- States: IDLE (credit 0), ACCUM (credit > 0), VEND, CHANGE.
- Event priority within one cycle: cancel > sel > coins. Any coin event that loses to cancel or sel, or arrives in VEND or CHANGE, is refused and pulses coin_reject.
- Coins (IDLE/ACCUM): add = coin_a*1 + coin_b*2 (both together add 3). If credit + add > MAX_CREDIT, the whole add is refused: coin_reject = 1 and credit is unchanged. Otherwise credit += add, and the state goes to ACCUM if the result is > 0.
- sel in ACCUM with credit >= PRICE: credit -= PRICE, go to VEND, dispense = 1. sel with credit < PRICE, or sel in IDLE: ignored, no output change.
- VEND: dispense stays high for exactly DISP_CYCLES cycles, counted with an internal counter. On the last cycle, go to CHANGE if credit > 0, else go to IDLE.
- cancel in ACCUM: go to CHANGE. cancel in IDLE, VEND or CHANGE: ignored.
- CHANGE: each cycle, change_pulse = 1 and credit -= 1. The cycle that takes credit to 0 is the last pulse, and the next state is IDLE. Total pulses equal the credit held on entry.
- digit = credit at all times, including during VEND and CHANGE.
- credit_full = (credit == MAX_CREDIT), registered alongside credit.
- busy = 1 exactly while the state is VEND or CHANGE.
- Credit arithmetic uses 5 bits internally so credit + 3 cannot wrap. The stored credit is 4 bits and never exceeds MAX_CREDIT.
- Reset asserted mid-VEND or mid-CHANGE: immediately returns to the reset values; any pending dispense or change is discarded.

Test Plan:
- Reset, then coin_a, coin_b (PRICE=3) -> digit 1, then 3; state ACCUM; no coin_reject.
- credit 3, sel -> digit 0; dispense high for exactly 4 cycles; busy high for those 4 cycles; return to IDLE with no change_pulse.
- credit 7, coin_b -> coin_reject pulses once, digit stays 7. Then coin_a -> digit 8, credit_full = 1.
- credit 5, sel -> dispense for 4 cycles, then change_pulse on 2 consecutive cycles; digit 2 -> 1 -> 0; IDLE.
- credit 2, sel -> ignored, digit stays 2. Then cancel -> 2 change_pulse, digit 0. A coin_a during CHANGE -> coin_reject, credit unaffected.
- Same-cycle events: cancel+sel+coin_a at credit 4 -> CHANGE (4 pulses), coin_reject once. coin_a+coin_b at credit 0 -> digit 3. Reset asserted during the 2nd dispense cycle -> all outputs 0 immediately.
